// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state encoding, PPROT bit positions and default window constants
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // PPROT[0] privileged, PPROT[1] non-secure, PPROT[2] instruction access
  localparam int unsigned PPROT_PRIV_BIT  = 0;
  localparam int unsigned PPROT_NSEC_BIT  = 1;
  localparam int unsigned PPROT_INSTR_BIT = 2;

  localparam int unsigned DEF_NUM           = 4;
  localparam int unsigned DEF_SIZE_IN_BYTES = 1024;
  localparam logic [31:0] DEF_ADDR_BASE     = 32'h0000_0000;
  localparam int unsigned DEF_TIMEOUT       = 16;

endpackage

// File: rtl/apb_addr_dec.sv
// rtl/apb_addr_dec.sv - window check plus slot index and one-hot select for an APB address map
module apb_addr_dec
  import apb_pkg::*;
#(
  parameter int unsigned P_NUM           = DEF_NUM,
  parameter int unsigned P_SIZE_IN_BYTES = DEF_SIZE_IN_BYTES,
  parameter logic [31:0] P_ADDR_BASE     = DEF_ADDR_BASE
) (
  input  logic [31:0]              addr_i,
  output logic                     hit_o,
  output logic [$clog2(P_NUM)-1:0] slot_o,
  output logic [P_NUM-1:0]         sel_o
);

  localparam int unsigned SLOT_W  = $clog2(P_NUM);
  localparam int unsigned OFS_LSB = $clog2(P_SIZE_IN_BYTES);

  logic [31:0] offset;

  assign offset = addr_i - P_ADDR_BASE;

  // Unsigned offset compare also rejects addresses below the base (they wrap high)
  always_comb begin
    hit_o  = (offset < 32'(P_NUM * P_SIZE_IN_BYTES));
    slot_o = offset[OFS_LSB +: SLOT_W];
    sel_o  = hit_o ? (P_NUM'(1) << slot_o) : '0;
  end

endmodule

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - valid/ready command to APB master bridge over four decoded slave windows
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned P_NUM           = DEF_NUM,
  parameter int unsigned P_SIZE_IN_BYTES = DEF_SIZE_IN_BYTES,
  parameter logic [31:0] P_ADDR_BASE     = DEF_ADDR_BASE,
  parameter int unsigned P_TIMEOUT       = DEF_TIMEOUT
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_wdata,
  input  logic [3:0]       cmd_strb,
  input  logic [2:0]       cmd_prot,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [P_NUM-1:0] PSEL,
  output logic [31:0]      PADDR,
  output logic             PWRITE,
  output logic [31:0]      PWDATA,
  output logic             PENABLE,
  output logic [2:0]       PPROT,
  output logic [3:0]       PSTRB,
  input  logic [31:0]      PRDATA0,
  input  logic [31:0]      PRDATA1,
  input  logic [31:0]      PRDATA2,
  input  logic [31:0]      PRDATA3,
  input  logic [P_NUM-1:0] PREADY,
  input  logic [P_NUM-1:0] PSLVERR
);

  localparam int unsigned SLOT_W = $clog2(P_NUM);
  localparam int unsigned TCNT_W = $clog2(P_TIMEOUT + 1);

  apb_state_e          state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic                write_q, write_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          strb_q, strb_d;
  logic [2:0]          prot_q, prot_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [P_NUM-1:0]    sel_q, sel_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                dec_hit;
  logic [SLOT_W-1:0]   dec_slot;
  logic [P_NUM-1:0]    dec_sel;
  logic [31:0]         prdata_sel;
  logic                pready_sel;
  logic                pslverr_sel;
  logic                bus_active;

  apb_addr_dec #(
    .P_NUM          (P_NUM),
    .P_SIZE_IN_BYTES(P_SIZE_IN_BYTES),
    .P_ADDR_BASE    (P_ADDR_BASE)
  ) u_addr_dec (
    .addr_i(cmd_addr),
    .hit_o (dec_hit),
    .slot_o(dec_slot),
    .sel_o (dec_sel)
  );

  assign pready_sel  = PREADY[slot_q];
  assign pslverr_sel = PSLVERR[slot_q];
  assign bus_active  = (state_q == SETUP) || (state_q == ACCESS);

  // Read-data mux for the slot latched at command accept
  always_comb begin
    case (slot_q)
      SLOT_W'(0): prdata_sel = PRDATA0;
      SLOT_W'(1): prdata_sel = PRDATA1;
      SLOT_W'(2): prdata_sel = PRDATA2;
      default:    prdata_sel = PRDATA3;
    endcase
  end

  // cmd_ready is masked by PRESET so it reads 0 for the whole reset pulse
  assign cmd_ready = (state_q == IDLE) && !PRESET;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign PSEL      = bus_active ? sel_q : '0;
  assign PENABLE   = (state_q == ACCESS);
  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PWDATA    = wdata_q;
  assign PPROT     = prot_q;
  assign PSTRB     = write_q ? strb_q : 4'h0;

  // Next-state logic: command capture, APB phase sequencing, completion and timeout
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    prot_d  = prot_q;
    slot_d  = slot_q;
    sel_d   = sel_q;
    tcnt_d  = tcnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          write_d = cmd_write;
          wdata_d = cmd_wdata;
          strb_d  = cmd_strb;
          prot_d  = cmd_prot;
          slot_d  = dec_slot;
          sel_d   = dec_sel;
          if (dec_hit) begin
            tcnt_d  = '0;
            state_d = SETUP;
          end else begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = RESP;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (pready_sel) begin
          err_d   = pslverr_sel;
          rdata_d = (write_q || pslverr_sel) ? 32'h0 : prdata_sel;
          state_d = RESP;
        end else if (tcnt_q == TCNT_W'(P_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      slot_q  <= '0;
      sel_q   <= '0;
      tcnt_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      prot_q  <= prot_d;
      slot_q  <= slot_d;
      sel_q   <= sel_d;
      tcnt_q  <= tcnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - self-checking bench for apb_cmd_master with APB slave model and reference memory
module tb_apb_cmd_master;

  localparam int          T_OUT = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic [2:0]  cmd_prot = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  PSEL;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PENABLE;
  logic [2:0]  PPROT;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
  logic [3:0]  PREADY;
  logic [3:0]  PSLVERR;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_cmd_master #(
    .P_NUM(4), .P_SIZE_IN_BYTES(1024), .P_ADDR_BASE(BASE), .P_TIMEOUT(T_OUT)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
    .PPROT(PPROT), .PSTRB(PSTRB),
    .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // ---------------- APB slave environment ----------------
  logic [31:0] smem [4][256];
  int  waits_cfg = 0;
  bit  hang_cfg  = 0;
  bit  err_cfg   = 0;
  bit  mem_clr   = 1;
  int  wcnt      = 0;

  assign PREADY  = (PENABLE && !hang_cfg && (wcnt >= waits_cfg)) ? PSEL : 4'h0;
  assign PSLVERR = err_cfg ? 4'hF : 4'h0;
  assign PRDATA0 = smem[0][PADDR[9:2]];
  assign PRDATA1 = smem[1][PADDR[9:2]];
  assign PRDATA2 = smem[2][PADDR[9:2]];
  assign PRDATA3 = smem[3][PADDR[9:2]];

  always @(posedge PCLK) begin
    if (PENABLE && (PSEL != 4'h0) && ((PREADY & PSEL) == 4'h0)) wcnt <= wcnt + 1;
    else wcnt <= 0;
    for (int s = 0; s < 4; s++) begin
      if (mem_clr) begin
        for (int w = 0; w < 256; w++) smem[s][w] <= 32'h0;
      end else if (PSEL[s] && PENABLE && PREADY[s] && PWRITE && !PSLVERR[s]) begin
        for (int b = 0; b < 4; b++)
          if (PSTRB[b]) smem[s][PADDR[9:2]][8*b +: 8] <= PWDATA[8*b +: 8];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] exp_mem [int];
  logic [31:0] exp_rdata;
  bit          exp_err;
  int          exp_lat, exp_acc;
  logic [3:0]  exp_psel;

  task automatic model_txn(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                           input logic [3:0] st, input int ws, input bit ei, input bit hg);
    logic [31:0] off, cur;
    int idx;
    off = a - BASE;
    if (off >= 32'd4096) begin
      exp_err = 1; exp_rdata = 0; exp_lat = 1; exp_acc = 0; exp_psel = 4'h0;
    end else begin
      exp_psel = 4'h1 << (off / 1024);
      idx = int'(off / 4);
      cur = exp_mem.exists(idx) ? exp_mem[idx] : 32'h0;
      if (hg) begin
        exp_err = 1; exp_rdata = 0; exp_acc = T_OUT; exp_lat = T_OUT + 2;
      end else begin
        exp_acc = ws + 1; exp_lat = ws + 3; exp_err = ei;
        if (wr) begin
          exp_rdata = 0;
          if (!ei) begin
            for (int b = 0; b < 4; b++) if (st[b]) cur[8*b +: 8] = wd[8*b +: 8];
            exp_mem[idx] = cur;
          end
        end else begin
          exp_rdata = ei ? 32'h0 : cur;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- transaction driver / monitor ----------------
  logic [31:0] got_rdata;
  bit          got_err, got_rsp, got_bad, got_psel_rsp;
  int          got_lat, got_acc, got_wait;
  logic [3:0]  got_psel;
  logic [1:0]  got_after;

  task automatic run_cmd(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr, input int ws,
                         input bit ei, input bit hg, input int bp);
    waits_cfg = ws; err_cfg = ei; hang_cfg = hg;
    got_bad = 0; got_acc = 0; got_psel = 4'h0; got_wait = 0;
    @(negedge PCLK);
    cmd_valid = 1; cmd_addr = a; cmd_write = wr; cmd_wdata = wd; cmd_strb = st; cmd_prot = pr;
    while (!cmd_ready && got_wait < 20) begin @(negedge PCLK); got_wait++; end
    @(negedge PCLK);
    cmd_valid = 0;
    got_lat = 1;
    while (!rsp_valid && got_lat < 64) begin
      if (PSEL != 4'h0) begin
        got_psel |= PSEL;
        if (PADDR !== a || PWRITE !== wr || PWDATA !== wd || PPROT !== pr ||
            PSTRB !== (wr ? st : 4'h0) || cmd_ready !== 1'b0) got_bad = 1;
      end
      if (PENABLE) got_acc++;
      @(negedge PCLK);
      got_lat++;
    end
    got_rsp = rsp_valid; got_rdata = rsp_rdata; got_err = rsp_err;
    got_psel_rsp = (PSEL != 4'h0) || PENABLE;
    for (int i = 0; i < bp; i++) begin
      if (!rsp_valid || rsp_rdata !== got_rdata || rsp_err !== got_err ||
          cmd_ready !== 1'b0 || PSEL !== 4'h0) got_bad = 1;
      @(negedge PCLK);
    end
    rsp_ready = 1;
    @(negedge PCLK);
    rsp_ready = 0;
    got_after = {cmd_ready, rsp_valid};
  endtask

  task automatic txn(input string tag, input logic [31:0] a, input bit wr, input logic [31:0] wd,
                     input logic [3:0] st, input logic [2:0] pr, input int ws,
                     input bit ei, input bit hg, input int bp);
    model_txn(a, wr, wd, st, ws, ei, hg);
    run_cmd(a, wr, wd, st, pr, ws, ei, hg, bp);
    chk({tag, "_accept"}, (got_wait < 20), 1);
    chk({tag, "_rsp_valid"}, got_rsp, 1);
    chk({tag, "_rdata"}, got_rdata, exp_rdata);
    chk({tag, "_err"}, got_err, exp_err);
    chk({tag, "_latency"}, got_lat, exp_lat);
    chk({tag, "_access_cycles"}, got_acc, exp_acc);
    chk({tag, "_psel"}, got_psel, exp_psel);
    chk({tag, "_bus_idle_at_rsp"}, got_psel_rsp, 0);
    chk({tag, "_stable"}, got_bad, 0);
    chk({tag, "_after_handshake"}, got_after, 2'b10);
  endtask

  logic [31:0] r_addr, r_wd;
  int          r_slot;

  initial begin
    // reset state
    repeat (3) @(negedge PCLK);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_psel", PSEL, 0);
    chk("reset_penable", PENABLE, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_paddr", PADDR, 0);
    PRESET = 0; mem_clr = 0;
    @(negedge PCLK);
    chk("release_cmd_ready", cmd_ready, 1);

    // write then read
    txn("wr_deadbeef", 32'h004, 1, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 0, 0, 0);
    txn("rd_deadbeef", 32'h004, 0, 32'h0, 4'hF, 3'd0, 0, 0, 0, 0);

    // slot decode walk
    for (int s = 0; s < 4; s++)
      txn("slot_wr", 32'(s * 1024), 1, 32'h1111_0000 + 32'(s * 32'h0101), 4'hF, 3'(s), 0, 0, 0, 0);
    for (int s = 0; s < 4; s++)
      txn("slot_rd", 32'(s * 1024), 0, 32'h0, 4'h0, 3'(s), 0, 0, 0, 0);

    // wait states, partial strobes
    txn("wait3_wr", 32'h808, 1, 32'hA5A5_5A5A, 4'b0101, 3'd5, 3, 0, 0, 0);
    txn("wait3_rd", 32'h808, 0, 32'h0, 4'h0, 3'd2, 3, 0, 0, 0);

    // errors
    txn("decode_err", 32'h1000, 0, 32'h0, 4'h0, 3'd0, 0, 0, 0, 0);
    txn("decode_err_hi", 32'hFFFF_FFFC, 1, 32'h1234_5678, 4'hF, 3'd0, 0, 0, 0, 0);
    txn("slverr_rd", 32'h004, 0, 32'h0, 4'h0, 3'd0, 1, 1, 0, 0);
    txn("timeout", 32'hC10, 1, 32'h7777_7777, 4'hF, 3'd7, 0, 0, 1, 0);

    // backpressure
    txn("backpressure", 32'h004, 0, 32'h0, 4'h0, 3'd0, 2, 0, 0, 5);

    // reset during ACCESS
    waits_cfg = 3; err_cfg = 0; hang_cfg = 0;
    @(negedge PCLK);
    cmd_valid = 1; cmd_addr = 32'h808; cmd_write = 0;
    got_wait = 0;
    while (!cmd_ready && got_wait < 20) begin @(negedge PCLK); got_wait++; end
    @(negedge PCLK);
    cmd_valid = 0;
    @(negedge PCLK);
    chk("rst_mid_in_access", PENABLE, 1);
    PRESET = 1;
    @(negedge PCLK);
    chk("rst_mid_psel", PSEL, 0);
    chk("rst_mid_penable", PENABLE, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 0);
    PRESET = 0;
    @(negedge PCLK);
    chk("rst_mid_release_ready", cmd_ready, 1);
    txn("after_reset", 32'h808, 0, 32'h0, 4'h0, 3'd0, 0, 0, 0, 0);

    // randomized traffic against the reference memory
    for (int i = 0; i < 40; i++) begin
      r_slot = $urandom_range(0, 3);
      r_addr = BASE + 32'(r_slot * 1024) + 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 7) == 0) r_addr = 32'h1000 + 32'($urandom_range(0, 1023) * 4);
      r_wd = $urandom;
      txn("rand", r_addr, 1'($urandom_range(0, 1)), r_wd, 4'($urandom_range(0, 15)),
          3'($urandom_range(0, 7)), $urandom_range(0, 3), ($urandom_range(0, 9) == 0), 0,
          $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
